pio_bidir_irq: RTL and testbench
================================

Name: pio_bidir_irq

Overview:
- Parametrised Avalon-MM bidirectional PIO with per-bit output enable, atomic bit set/clear, edge capture and maskable interrupt.
- Next generation of the system's fixed 8-bit LCD data/direction port.
- Sits between the Nios II data master (Avalon slave s1) and external tri-state pins such as the LCD bus, keypad or GPIO header.
- One instance per pin group.

Parameters:
- WIDTH, 8: number of bidirectional pins, 1..32.
- EDGE_TYPE, 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.
- RESET_DIR, 0: reset value of the direction register, WIDTH bits. 1 = output.
- RESET_OUT, 0: reset value of the data_out register, WIDTH bits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- irq  out  1  level interrupt, active-high
- bidir_port  inout  WIDTH  external pins

Behaviour:
- Clock and reset: clk is the clock. reset_n is asynchronous and active-low. All flops reset asynchronously.
- Reset values:
  - readdata = 0
  - data_out = RESET_OUT
  - data_dir = RESET_DIR
  - irq_mask = 0
  - edge_cap = 0
  - synchroniser and previous-sample flops = 0
  - irq = 0
- Write strobe: wr = chipselect & ~write_n.
- Register map (address):
  - 0 DATA. Read returns synchronised pin value. Write sets data_out = writedata[WIDTH-1:0].
  - 1 DIR. Read/write. Bit = 1 drives the pin.
  - 2 IRQMASK. Read/write.
  - 3 EDGECAP. Read returns edge_cap. Write-1-to-clear per bit.
  - 4 OUTSET. Write sets data_out |= wd. Reads return 0.
  - 5 OUTCLR. Write sets data_out &= ~wd. Reads return 0.
  - 6, 7: reserved. Reads return 0; writes are ignored.
- Read timing: readdata is registered every clk regardless of chipselect.
  - Value reflects the address presented in the previous cycle: 1-cycle read latency, no waitrequest.
  - Upper 32-WIDTH bits are always 0.
- Pin drive: bidir_port[i] = data_dir[i] ? data_out[i] : Z.
  - A driven pin reads back its own output value after the synchroniser delay.
- Input path: sync_in is the two-flop synchronised bidir_port.
  - DATA read shows a pin change no earlier than 2 clk after the pin changes, plus the 1-cycle read latency.
- Edge detect:
  - prev <= sync_in every clk.
  - Rising edge = sync_in & ~prev. Falling edge = ~sync_in & prev. Any edge = XOR.
  - edge_cap[i] <= (edge_cap[i] & ~clr[i]) | edge[i].
  - If a detected edge and a W1C clear hit the same bit in the same cycle, the edge wins and the bit stays 1.
- irq = |(edge_cap & irq_mask), registered, so it asserts 1 clk after edge_cap sets.
  - Clearing a mask bit or edge bit deasserts irq on the following clk.
- Output-enabled pins also generate edges from their own output toggles. This is intended.
- Reset mid-operation: all state returns to reset values immediately. Pins with RESET_DIR = 0 float.
- No internal FSM beyond the register pipeline. The edge pipeline is sync1 -> sync2 -> prev -> edge_cap -> irq.

Optional Feature:
- Macro: PIO_INPUT_SYNC_EN.
- Defined: two-flop synchroniser present, as described above. Edge-to-irq latency is 4 clk from the pin change.
- Undefined: sync_in = bidir_port directly, for pins already synchronous to clk.
  - Edge-to-irq latency is 2 clk from the pin change.
  - DATA read reflects the pin value at the sampling edge.

Decomposition:
- Package pio_pkg:
  - address constants ADDR_DATA..ADDR_OUTCLR
  - EDGE_RISE / EDGE_FALL / EDGE_ANY localparams
  - read-latency constant = 1
- Sub-module pio_edge_capture (WIDTH, EDGE_TYPE):
  - Inputs: sync_in, clr mask.
  - Contains the prev register and the W1C capture register.
  - Outputs: edge_cap.
- Top level holds the synchroniser, data/dir/mask registers, tri-state assigns, read mux and irq flop.

Test Plan:
- Reset with RESET_DIR = 8'h0F, RESET_OUT = 8'h05: read DIR -> 0x0000000F; pins[3:0] = 4'b0101, pins[7:4] = Z; irq = 0.
- Write DATA = 0xA5, then OUTSET = 0x0A, then OUTCLR = 0x81 with DIR = 0xFF: pins become 0xA5 -> 0xAF -> 0x2E; DATA read-back after sync = 0x2E.
- EDGE_TYPE = 0, DIR = 0, IRQMASK = 0x01, bench drives pin0 0->1: EDGECAP reads 0x01; irq rises 4 clk after the pin edge (2 clk without PIO_INPUT_SYNC_EN). A pin0 1->0 transition captures nothing.
- Write EDGECAP = 0x01 in the same cycle a new rising edge reaches edge_cap bit 0: bit stays 1, irq stays high. Clearing with no edge present drops irq 1 clk later.
- EDGE_TYPE = 2, IRQMASK = 0x00, toggle pin5: EDGECAP = 0x20 but irq = 0. Then write IRQMASK = 0x20: irq = 1 next clk.
- Read addresses 4..7 -> 0. Assert reset_n low mid-transfer: readdata, edge_cap and irq are 0 immediately, with no clk edge required.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the bidirectional PIO: register addresses, edge modes, read latency.
package pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5,
    ADDR_RSVD6   = 3'd6,
    ADDR_RSVD7   = 3'd7
  } pio_addr_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  localparam int unsigned READ_LATENCY = 1;

endpackage

// File: rtl/pio_bidir_irq_if.sv
// Avalon-MM slave bus (s1) of the bidirectional PIO.
interface pio_bidir_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_edge_capture.sv
// Edge detector on the synchronised pin vector with a write-1-to-clear capture register.
module pio_edge_capture
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sync_in,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] edge_cap
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] edge_det;

  always_comb begin
    prev_d = sync_in;
    case (EDGE_TYPE)
      EDGE_FALL: edge_det = ~sync_in & prev_q;
      EDGE_ANY:  edge_det = sync_in ^ prev_q;
      default:   edge_det = sync_in & ~prev_q;
    endcase
    // A fresh edge overrides a simultaneous clear of the same bit.
    cap_d = (cap_q & ~clr) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      cap_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cap_q  <= cap_d;
    end
  end

  assign edge_cap = cap_q;

endmodule

// File: rtl/pio_bidir_irq.sv
// Avalon-MM bidirectional PIO with per-bit direction, set/clear, edge capture and irq.
// Optional PIO_INPUT_SYNC_EN adds a two-flop input synchroniser.
module pio_bidir_irq
  import pio_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      EDGE_TYPE = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_DIR = '0,
  parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_bidir_irq_if.slave       s1,
  output logic                 irq,
  inout  wire  [WIDTH-1:0]     bidir_port
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] data_dir_q, data_dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wd;
  logic             wr;
  pio_addr_e        addr;
  logic             wd_unused;

`ifdef PIO_INPUT_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bidir_port;
      sync2_q <= sync1_q;
    end
  end

  assign sync_in = sync2_q;
`else
  assign sync_in = bidir_port;
`endif

  assign wr        = s1.chipselect & ~s1.write_n;
  assign addr      = pio_addr_e'(s1.address);
  assign wd        = s1.writedata[WIDTH-1:0];
  assign wd_unused = ^s1.writedata;

  always_comb begin
    data_out_d = data_out_q;
    data_dir_d = data_dir_q;
    irq_mask_d = irq_mask_q;
    clr        = '0;
    if (wr) begin
      case (addr)
        ADDR_DATA:    data_out_d = wd;
        ADDR_DIR:     data_dir_d = wd;
        ADDR_IRQMASK: irq_mask_d = wd;
        ADDR_EDGECAP: clr        = wd;
        ADDR_OUTSET:  data_out_d = data_out_q | wd;
        ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
        default:      ;
      endcase
    end
  end

  // Read mux is sampled every cycle, independent of chipselect.
  always_comb begin
    readdata_d = '0;
    case (addr)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_in;
      ADDR_DIR:     readdata_d[WIDTH-1:0] = data_dir_q;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_cap;
      default:      readdata_d = '0;
    endcase
    irq_d = |(edge_cap & irq_mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      data_dir_q <= RESET_DIR;
      irq_mask_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      data_dir_q <= data_dir_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  pio_edge_capture #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .sync_in  (sync_in),
    .clr      (clr),
    .edge_cap (edge_cap)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = data_dir_q[i] ? data_out_q[i] : 1'bz;
  end

  assign s1.readdata = readdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Bench for pio_bidir_irq: a rising-edge and an any-edge instance share the bus stimulus,
// checked every cycle against a pin-history model.
module tb_pio_bidir_irq;

`ifdef PIO_INPUT_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  localparam int EXP_LAT = SYNC_DLY + 2;
  localparam logic [7:0] R_DIR = 8'h0F;
  localparam logic [7:0] R_OUT = 8'h05;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pio_bidir_irq_if bus_a ();
  pio_bidir_irq_if bus_b ();
  logic irq_a, irq_b;
  wire [7:0] pins_a, pins_b;
  logic [7:0] tb_oe, tb_val;

  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign pins_a[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    assign pins_b[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  pio_bidir_irq #(.WIDTH(8), .EDGE_TYPE(0), .RESET_DIR(R_DIR), .RESET_OUT(R_OUT)) u_rise (
    .clk(clk), .reset_n(reset_n), .s1(bus_a), .irq(irq_a), .bidir_port(pins_a));
  pio_bidir_irq #(.WIDTH(8), .EDGE_TYPE(2), .RESET_DIR(R_DIR), .RESET_OUT(R_OUT)) u_any (
    .clk(clk), .reset_n(reset_n), .s1(bus_b), .irq(irq_b), .bidir_port(pins_b));

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference state: registers as seen by software, plus every pin value sampled since reset.
  logic [7:0]  m_out, m_dir, m_mask;
  logic [7:0]  m_cap [2];
  logic        m_irq [2];
  logic [31:0] m_rd  [2];
  logic [7:0]  hist  [$];
  logic [7:0]  pv;

  function automatic logic [7:0] seen(input int n);
    int idx;
    idx = n - SYNC_DLY;
    if (idx < 0) return 8'h00;
    return hist[idx];
  endfunction

  task automatic model_reset();
    m_out = R_OUT; m_dir = R_DIR; m_mask = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_cap[k] = 8'h00; m_irq[k] = 1'b0; m_rd[k] = 32'h0;
    end
    hist.delete();
    tb_oe = ~R_DIR;
  endtask

  task automatic step(input logic cs, input logic wn, input logic [2:0] a,
                      input logic [31:0] wd, input logic [7:0] pins);
    logic [7:0] cur, prv, clr, edg;
    logic [7:0] n_out, n_dir, n_mask;
    logic [7:0] n_cap [2];
    logic       n_irq [2];
    logic [31:0] n_rd [2];
    int n;
    bit wr;
    bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.address = a; bus_a.writedata = wd;
    bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.address = a; bus_b.writedata = wd;
    tb_val = pins;
    tb_oe  = ~m_dir;
    hist.push_back((m_dir & m_out) | (~m_dir & pins));
    n   = hist.size() - 1;
    cur = seen(n);
    prv = seen(n - 1);
    wr  = cs && !wn;
    clr = (wr && a == 3'd3) ? wd[7:0] : 8'h00;
    for (int k = 0; k < 2; k++) begin
      case (a)
        3'd0:    n_rd[k] = {24'h0, cur};
        3'd1:    n_rd[k] = {24'h0, m_dir};
        3'd2:    n_rd[k] = {24'h0, m_mask};
        3'd3:    n_rd[k] = {24'h0, m_cap[k]};
        default: n_rd[k] = 32'h0;
      endcase
      n_irq[k] = (m_cap[k] & m_mask) != 8'h00;
      edg = (k == 0) ? (cur & ~prv) : (cur ^ prv);
      n_cap[k] = (m_cap[k] & ~clr) | edg;
    end
    n_out = m_out; n_dir = m_dir; n_mask = m_mask;
    if (wr) begin
      case (a)
        3'd0: n_out = wd[7:0];
        3'd1: n_dir = wd[7:0];
        3'd2: n_mask = wd[7:0];
        3'd4: n_out = m_out | wd[7:0];
        3'd5: n_out = m_out & ~wd[7:0];
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    m_out = n_out; m_dir = n_dir; m_mask = n_mask;
    for (int k = 0; k < 2; k++) begin
      m_cap[k] = n_cap[k]; m_irq[k] = n_irq[k]; m_rd[k] = n_rd[k];
    end
    tb_oe = ~m_dir;
    @(negedge clk);
    check("rd_rise", bus_a.readdata, m_rd[0]);
    check("rd_any", bus_b.readdata, m_rd[1]);
    check("irq_rise", {31'h0, irq_a}, {31'h0, m_irq[0]});
    check("irq_any", {31'h0, irq_b}, {31'h0, m_irq[1]});
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d); step(1'b1, 1'b0, a, d, pv); endtask
  task automatic rd_reg(input logic [2:0] a); step(1'b1, 1'b1, a, 32'h0, pv); endtask
  task automatic idle(input int cnt);
    for (int j = 0; j < cnt; j++) step(1'b0, 1'b1, 3'd0, 32'h0, pv);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen_irq;
    pv = 8'hA0;
    tb_val = pv;
    bus_a.chipselect = 0; bus_a.write_n = 1; bus_a.address = 0; bus_a.writedata = 0;
    bus_b.chipselect = 0; bus_b.write_n = 1; bus_b.address = 0; bus_b.writedata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rd", bus_a.readdata, 32'h0);
    check("rst_irq", {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;

    // Reset direction/output values; upper nibble driven by the bench.
    rd_reg(3'd1);
    check("dir_reset", bus_a.readdata, 32'h0000_000F);
    idle(3);
    rd_reg(3'd0);
    check("pins_reset", bus_a.readdata, 32'h0000_00A5);
    wr_reg(3'd3, 32'hFF);

    // Data write, atomic set and clear.
    wr_reg(3'd1, 32'hFF);
    wr_reg(3'd0, 32'hFFFF_FFA5);
    idle(3); rd_reg(3'd0);
    check("data_a5", bus_a.readdata, 32'h0000_00A5);
    wr_reg(3'd4, 32'h0A);
    idle(3); rd_reg(3'd0);
    check("outset_af", bus_a.readdata, 32'h0000_00AF);
    wr_reg(3'd5, 32'h81);
    idle(3); rd_reg(3'd0);
    check("outclr_2e", bus_a.readdata, 32'h0000_002E);

    // Rising edge on pin0 and irq latency.
    pv = 8'h00;
    wr_reg(3'd1, 32'h00);
    idle(4);
    wr_reg(3'd3, 32'hFF);
    wr_reg(3'd2, 32'h01);
    idle(2);
    check("irq_quiet", {31'h0, irq_a}, 32'h0);
    pv = 8'h01;
    lat = 0; seen_irq = 0;
    for (int j = 1; j <= 10 && !seen_irq; j++) begin
      idle(1);
      if (irq_a) begin lat = j; seen_irq = 1; end
    end
    check("irq_latency", lat, EXP_LAT);
    rd_reg(3'd3);
    check("cap_rise", bus_a.readdata, 32'h01);
    wr_reg(3'd3, 32'h01);
    pv = 8'h00;
    idle(4);
    rd_reg(3'd3);
    check("fall_ignored", bus_a.readdata, 32'h00);
    check("fall_any", bus_b.readdata, 32'h01);

    // Edge and W1C clear landing in the same cycle.
    pv = 8'h01; idle(4);
    pv = 8'h00; idle(4);
    pv = 8'h01;
    for (int j = 0; j <= SYNC_DLY; j++) begin
      if (j == SYNC_DLY) wr_reg(3'd3, 32'h01);
      else idle(1);
    end
    rd_reg(3'd3);
    check("edge_wins", bus_a.readdata, 32'h01);
    check("irq_held", {31'h0, irq_a}, 32'h1);
    wr_reg(3'd3, 32'h01);
    idle(1);
    check("irq_cleared", {31'h0, irq_a}, 32'h0);

    // Any-edge capture masked, then unmasked.
    wr_reg(3'd2, 32'h00);
    wr_reg(3'd3, 32'hFF);
    idle(2);
    pv = 8'h21; idle(4);
    pv = 8'h01; idle(4);
    rd_reg(3'd3);
    check("cap_any_pin5", bus_b.readdata, 32'h20);
    check("masked_irq", {31'h0, irq_b}, 32'h0);
    wr_reg(3'd2, 32'h20);
    idle(1);
    check("unmask_irq", {31'h0, irq_b}, 32'h1);

    // Write-only and reserved addresses read as zero.
    for (int a = 4; a < 8; a++) begin
      rd_reg(3'(a));
      check($sformatf("rsvd_rd%0d", a), bus_a.readdata, 32'h0);
    end

    // Asynchronous reset with a read outstanding and irq high.
    rd_reg(3'd2);
    step(1'b1, 1'b1, 3'd1, 32'h0, pv);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_rd", bus_b.readdata, 32'h0);
    check("async_rst_irq", {31'h0, irq_b}, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_reg(3'd3);
    rd_reg(3'd1);
    check("dir_after_rst", bus_a.readdata, 32'h0F);

    // Random traffic against the model.
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 3) == 0) pv = 8'($urandom);
      step(1'($urandom), 1'($urandom), 3'($urandom), $urandom, pv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
